// File: rtl/rx_buf_rd_sched_if.sv
// ---------------------------------------------------------------------------
// rx_buf_rd_sched_if
// Bundles the receive-buffer read side and the two consumer ports of the
// read scheduler.
//   wr_word          : one pulse per word committed to the buffer
//   rd_start         : one-word read strobe to the buffer (send_start)
//   rd_data          : buffer read data, RD_LAT cycles after rd_start
//   reqN_valid/len   : burst request from consumer N (0 = kernel, 1 = host)
//   reqN_ready       : one-cycle acceptance pulse
//   m_valid/data/id/last : returned word stream, no backpressure
//   level            : words available and not yet issued
//   overflow         : sticky, word written while buffer already full
// The master modport is the scheduler; the slave modport is its environment.
// ---------------------------------------------------------------------------
interface rx_buf_rd_sched_if #(
    parameter int DEPTH_LOG2 = 16,
    parameter int LEN_W      = 9
);
    logic                  wr_word;
    logic                  rd_start;
    logic [63:0]           rd_data;
    logic                  req0_valid;
    logic                  req1_valid;
    logic [LEN_W-1:0]      req0_len;
    logic [LEN_W-1:0]      req1_len;
    logic                  req0_ready;
    logic                  req1_ready;
    logic                  m_valid;
    logic [63:0]           m_data;
    logic                  m_id;
    logic                  m_last;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;

    modport master (
        input  wr_word, rd_data, req0_valid, req1_valid, req0_len, req1_len,
        output rd_start, req0_ready, req1_ready, m_valid, m_data, m_id, m_last,
               level, overflow
    );

    modport slave (
        output wr_word, rd_data, req0_valid, req1_valid, req0_len, req1_len,
        input  rd_start, req0_ready, req1_ready, m_valid, m_data, m_id, m_last,
               level, overflow
    );
endinterface

// File: rtl/rx_buf_rd_sched.sv
// ---------------------------------------------------------------------------
// rx_buf_rd_sched
// Read scheduler for the GTP receive buffer. Tracks buffer occupancy, grants
// burst requests from two consumers round-robin, issues one-word read strobes
// and tags the returned words with requester ID and last-word flag.
//   ap_clk   : sole clock
//   ap_rst_n : synchronous active-low reset
//   bus      : buffer read side and consumer ports (rx_buf_rd_sched_if.master)
// ---------------------------------------------------------------------------
module rx_buf_rd_sched #(
    parameter int RD_LAT     = 3,
    parameter int DEPTH_LOG2 = 16,
    parameter int LEN_W      = 9
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    rx_buf_rd_sched_if.master    bus
);

    localparam logic [DEPTH_LOG2:0] LVL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_W-1:0]     r_remain;
    logic                 r_cur_id;
    logic                 r_last_grant;
    logic [DEPTH_LOG2:0]  r_level;
    logic                 r_overflow;
    logic                 r_rd_start;
    logic                 r_rd_last;
    logic [RD_LAT-1:0]    r_tag_vld;
    logic [RD_LAT-1:0]    r_tag_id;
    logic [RD_LAT-1:0]    r_tag_last;

    logic                 w_issue;
    logic                 w_grant;
    logic                 w_gnt_id;
    logic [LEN_W-1:0]     w_gnt_len;
    logic                 w_inflight;

    assign w_issue   = (r_state == S_ISSUE) && (r_level != '0) && (r_remain != '0);
    // With both requesting, the one not granted last wins.
    assign w_gnt_id  = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_gnt_len = w_gnt_id ? bus.req1_len : bus.req0_len;
    // Gated by reset so no acceptance pulse escapes while reset is held.
    assign w_grant   = ap_rst_n && (r_state == S_IDLE) && (bus.req0_valid || bus.req1_valid);

    // Words still to come out after this edge: the strobe just launched plus
    // every tag stage except the output one. Leaving DRAIN on the cycle the
    // final word is presented lets the next grant follow immediately after it.
    always_comb begin
        w_inflight = r_rd_start;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            w_inflight = w_inflight | r_tag_vld[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant && (w_gnt_len != '0)) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_issue && (r_remain == LEN_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_inflight) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state      <= S_IDLE;
            r_remain     <= '0;
            r_cur_id     <= 1'b0;
            r_last_grant <= 1'b1;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_rd_start   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_tag_vld    <= '0;
            r_tag_id     <= '0;
            r_tag_last   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant) begin
                r_remain     <= w_gnt_len;
                r_cur_id     <= w_gnt_id;
                r_last_grant <= w_gnt_id;
            end else if (w_issue) begin
                r_remain <= r_remain - 1'b1;
            end

            // Tag entry rides with the strobe, then enters the shift register
            // so it reaches the output exactly when the buffer returns data.
            r_rd_start <= w_issue;
            r_rd_last  <= w_issue && (r_remain == LEN_W'(1));
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_id[i]   <= r_tag_id[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
            end
            r_tag_vld[0]  <= r_rd_start;
            r_tag_id[0]   <= r_rd_start & r_cur_id;
            r_tag_last[0] <= r_rd_last;

            // A write and an issue in the same cycle cancel out.
            if (bus.wr_word && !w_issue) begin
                if (r_level != LVL_MAX) begin
                    r_level <= r_level + 1'b1;
                end
            end else if (w_issue && !bus.wr_word) begin
                r_level <= r_level - 1'b1;
            end

            if (bus.wr_word && (r_level == LVL_MAX)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.rd_start   = r_rd_start;
    assign bus.req0_ready = w_grant && !w_gnt_id;
    assign bus.req1_ready = w_grant && w_gnt_id;
    assign bus.m_valid    = r_tag_vld[RD_LAT-1];
    assign bus.m_id       = r_tag_id[RD_LAT-1];
    assign bus.m_last     = r_tag_last[RD_LAT-1];
    assign bus.m_data     = r_tag_vld[RD_LAT-1] ? bus.rd_data : 64'd0;
    assign bus.level      = r_level;
    assign bus.overflow   = r_overflow;

endmodule

// File: doc/rx_buf_rd_sched.md
# rx_buf_rd_sched

Read scheduler for the GTP receive buffer. It sits in the `ap_clk` domain between the receive buffer's read side and two downstream consumers: consumer 0 is the kernel datapath and consumer 1 is the host readback path. It tracks buffer occupancy, grants burst requests round-robin, and issues one-word read strobes to the buffer (its `send_start` input). Returned `sfp_rd_data` words are tagged with requester ID and last-word flag.

## Interface
- `RD_LAT`, 3, cycles from `rd_start` high to the matching word on `rd_data`.
- `DEPTH_LOG2`, 16, log2 of the buffer depth in 64-bit words.
- `LEN_W`, 9, width of the burst-length fields; max burst is 2^LEN_W−1 words.

Ports:
- `ap_clk`  in  1  sole clock.
- `ap_rst_n`  in  1  reset, synchronous, active-low.
- `wr_word`  in  1  one pulse per word committed to the buffer, already in the `ap_clk` domain.
- `rd_start`  out  1  registered read strobe, one word per high cycle; drives buffer `send_start`.
- `rd_data`  in  64  buffer read data (`sfp_rd_data`).
- `req0_valid`, `req1_valid`  in  1  burst request, held high until ready.
- `req0_len`, `req1_len`  in  LEN_W  words requested; held stable while valid.
- `req0_ready`, `req1_ready`  out  1  one-cycle acceptance pulse.
- `m_valid`  out  1  returned word valid; no backpressure, so the consumer must sink every word.
- `m_data`  out  64  returned word.
- `m_id`  out  1  requester the word belongs to.
- `m_last`  out  1  final word of the burst.
- `level`  out  DEPTH_LOG2+1  words available and not yet issued.
- `overflow`  out  1  sticky; set when `wr_word` arrives while `level` == 2^DEPTH_LOG2.

## Operation
- State machine: IDLE, ISSUE, DRAIN.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester.
  - With one valid requester, grant it.
  - With both valid, grant the one not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - In the acceptance cycle: pulse `reqN_ready`, latch len into `remain` and the ID into `cur_id`, update `last_grant`.
  - Next state is ISSUE. If len == 0, go straight back to IDLE: no reads are issued and no `m_last` is produced.
- **ISSUE**
  - Issue a read when `level` != 0 (registered value) and `remain` != 0.
  - Issuing means: `rd_start` goes high next cycle, `remain` is decremented, and a {valid, id, last = (`remain` == 1)} entry is pushed into an RD_LAT-deep tag shift register.
  - When `level` == 0, stall with `rd_start` low. Stay in ISSUE; no timeout.
  - When the final read issues, go to DRAIN.
- **DRAIN**
  - Wait until the tag shift register holds no valid entry, then go to IDLE.
  - A new grant is therefore never made while words are in flight.
- **Occupancy**
  - `level` <= `level` + `wr_word` − issue each cycle.
  - A simultaneous `wr_word` and issue leaves `level` unchanged.
  - Saturate at 2^DEPTH_LOG2; `wr_word` at saturation sets `overflow` and `level` holds.
  - `level` never underflows, because issue requires `level` != 0.
- **Return path**
  - `m_valid`, `m_id`, `m_last` are taken from the shift-register output.
  - `m_data` = `rd_data` in the same cycle (combinational pass-through), gated to 0 when `m_valid` is low.

## Timing
- Reset values: `rd_start` 0, `reqN_ready` 0, `m_valid` 0, `m_data` 0, `m_id` 0, `m_last` 0, `level` 0, `overflow` 0, state IDLE, tag register cleared, `last_grant` 1.
- Request `valid` at cycle t in IDLE → `ready` at t. First `rd_start` no earlier than t+2, since ISSUE is entered at t+1 and `rd_start` is registered.
- `rd_start` at cycle c → `m_valid` with the same word at c+RD_LAT.
- Throughput: one word per cycle while `level` > 0. A back-to-back burst of N words from a full buffer produces N consecutive `m_valid` cycles.
- Minimum request-to-request gap is N+RD_LAT+2 cycles.
- Reset mid-burst: all state clears and in-flight tags are dropped. The buffer's read pointer is not reset by this block, so the system must reset the buffer together with it.
- `req` deasserted before `ready` is legal; no grant is made.

## Test plan
- **Reset:** hold `ap_rst_n`=0 for 4 cycles with `req0_valid`=1 → `ready`, `rd_start`, `m_valid` all 0, `level`=0; after release with `level`=0, `req0` is granted but `rd_start` stays 0.
- **Single burst:** 8 `wr_word` pulses, then `req0` len=8.
  - Expect 8 consecutive `rd_start` pulses.
  - `m_valid` 8 cycles starting RD_LAT after the first pulse.
  - `m_id`=0; `m_last` only on the 8th word.
  - `level` ends at 0.
- **Starvation:** `level`=2, `req1` len=5 → 2 reads, stall, then 3 more reads, each in the cycle after the corresponding `wr_word` raises `level`; `m_last` on the 5th word.
- **Round-robin:** both requests held continuously with len=1 each and `level`=10 → grants alternate 0,1,0,1. Each grant occurs only after the previous `m_last` has drained.
- **Simultaneous events:** `wr_word` and issue in the same cycle → `level` unchanged. `wr_word` with `level`=65536 → `overflow`=1, sticky until reset.
- **Zero length and mid-burst reset:** len=0 request → `ready` pulse with no `rd_start` and no `m_valid`. Assert reset during ISSUE of a 20-word burst → all outputs 0 on the next cycle, and no stale `m_valid` after release.
